// File: rtl/mem_dados_param.sv
// Parametrised little-endian data memory with byte/half/word access,
// valid/ready request handshake and a registered, error-flagged response.
module mem_dados_param #(
    parameter int DEPTH        = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_escrita,
    input  logic [1:0]            req_tamanho,
    input  logic                  req_sem_sinal,
    input  logic [ADDR_WIDTH-1:0] endereco,
    input  logic [31:0]           valor_reg2,
    output logic                  resp_valid,
    output logic [31:0]           dado_saida,
    output logic                  erro_acesso
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic {
        OCIOSO,
        RESPOSTA
    } estado_t;

    estado_t estado;

    logic [31:0]   mem [DEPTH];
    logic [IW-1:0] indice;
    logic [1:0]    offset;
    logic          fora_faixa;
    logic          erro;
    logic          aceita;
    logic [31:0]   palavra;
    logic [7:0]    byte_sel;
    logic [15:0]   meia_sel;
    logic [31:0]   carga;
    logic [3:0]    mascara;
    logic [31:0]   dado_escrita;

    assign indice     = endereco[IW+1:2];
    assign offset     = endereco[1:0];
    assign fora_faixa = (endereco >> (IW + 2)) != '0;
    assign aceita     = req_valid && req_ready;

    always_comb begin
        erro = fora_faixa;
        unique case (req_tamanho)
            2'b00:   erro = fora_faixa;
            2'b01:   erro = fora_faixa || offset[0];
            2'b10:   erro = fora_faixa || (offset != 2'b00);
            default: erro = 1'b1;
        endcase
    end

    assign palavra  = mem[indice];
    assign byte_sel = palavra[{offset, 3'b000} +: 8];
    assign meia_sel = palavra[{offset[1], 4'b0000} +: 16];

    always_comb begin
        carga = palavra;
        unique case (req_tamanho)
            2'b00:
                carga = req_sem_sinal ? {24'b0, byte_sel}
                                      : {{24{byte_sel[7]}}, byte_sel};
            2'b01:
                carga = req_sem_sinal ? {16'b0, meia_sel}
                                      : {{16{meia_sel[15]}}, meia_sel};
            default:
                carga = palavra;
        endcase
    end

    // Store data is replicated across lanes so the mask alone picks the target.
    always_comb begin
        mascara      = 4'b0000;
        dado_escrita = valor_reg2;
        unique case (req_tamanho)
            2'b00: begin
                mascara      = 4'b0001 << offset;
                dado_escrita = {4{valor_reg2[7:0]}};
            end
            2'b01: begin
                mascara      = offset[1] ? 4'b1100 : 4'b0011;
                dado_escrita = {2{valor_reg2[15:0]}};
            end
            2'b10: begin
                mascara      = 4'b1111;
                dado_escrita = valor_reg2;
            end
            default: begin
                mascara      = 4'b0000;
                dado_escrita = valor_reg2;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if (CLEAR_ON_RST) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else if (aceita && req_escrita && !erro) begin
            for (int n = 0; n < 4; n++) begin
                if (mascara[n]) begin
                    mem[indice][8*n +: 8] <= dado_escrita[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= OCIOSO;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            dado_saida  <= '0;
            erro_acesso <= 1'b0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        estado      <= RESPOSTA;
                        req_ready   <= 1'b0;
                        resp_valid  <= 1'b1;
                        erro_acesso <= erro;
                        dado_saida  <= (erro || req_escrita) ? '0 : carga;
                    end
                end
                RESPOSTA: begin
                    estado     <= OCIOSO;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
                default: begin
                    estado     <= OCIOSO;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dados_param.sv
// Scoreboard bench for mem_dados_param: directed requests push expected
// responses, a negedge monitor pops and compares on every resp_valid.
module tb_mem_dados_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_escrita;
    logic [1:0]  req_tamanho;
    logic        req_sem_sinal;
    logic [31:0] endereco;
    logic [31:0] valor_reg2;
    logic        resp_valid;
    logic [31:0] dado_saida;
    logic        erro_acesso;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        string       nm;
    } exp_t;

    exp_t q[$];

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SR = 2'b11;

    mem_dados_param #(
        .DEPTH(64),
        .ADDR_WIDTH(32),
        .CLEAR_ON_RST(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_escrita(req_escrita),
        .req_tamanho(req_tamanho),
        .req_sem_sinal(req_sem_sinal),
        .endereco(endereco),
        .valor_reg2(valor_reg2),
        .resp_valid(resp_valid),
        .dado_saida(dado_saida),
        .erro_acesso(erro_acesso)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if (!reset && resp_valid) begin
            exp_t x;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: got dado=%h erro=%b, none expected",
                         dado_saida, erro_acesso);
            end else begin
                x = q.pop_front();
                if (dado_saida !== x.d || erro_acesso !== x.e) begin
                    bad++;
                    $display("FAIL %s: got dado=%h erro=%b, want dado=%h erro=%b",
                             x.nm, dado_saida, erro_acesso, x.d, x.e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e, input string nm);
        exp_t x;
        x.d  = d;
        x.e  = e;
        x.nm = nm;
        q.push_back(x);
    endtask

    task automatic req(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] v,
                       input logic [31:0] ed, input logic ee, input string nm);
        bit ok;
        bit r;
        @(posedge clock);
        #1;
        push_exp(ed, ee, nm);
        req_escrita   = w;
        req_tamanho   = sz;
        req_sem_sinal = uns;
        endereco      = a;
        valor_reg2    = v;
        req_valid     = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clock);
            r = req_ready;
            @(posedge clock);
            ok = r;
        end
        #1;
        req_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_accept: not accepted within 10 cycles", nm);
            void'(q.pop_back());
        end else begin
            @(negedge clock);
            check({nm, "_latency"}, {31'b0, resp_valid}, 32'd1);
        end
    endtask

    initial begin
        logic [3:0] rdy;
        int         acc;

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_escrita   = 1'b0;
        req_tamanho   = SW;
        req_sem_sinal = 1'b0;
        endereco      = '0;
        valor_reg2    = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_dado", dado_saida, 32'd0);
        check("rst_erro", {31'b0, erro_acesso}, 32'd0);

        req(0, SW, 0, 32'h10, 0, 32'h0, 0, "ld_w_10_after_rst");

        req(1, SW, 0, 32'h20, 32'h8001_7F80, 32'h0, 0, "st_w_20");
        req(0, SB, 0, 32'h20, 0, 32'hFFFF_FF80, 0, "ld_b_20_s");
        req(0, SB, 1, 32'h21, 0, 32'h0000_007F, 0, "ld_b_21_u");
        req(0, SB, 0, 32'h23, 0, 32'hFFFF_FF80, 0, "ld_b_23_s");
        req(0, SB, 1, 32'h22, 0, 32'h0000_0001, 0, "ld_b_22_u");
        req(0, SH, 0, 32'h20, 0, 32'h0000_7F80, 0, "ld_h_20_s");
        req(0, SH, 0, 32'h22, 0, 32'hFFFF_8001, 0, "ld_h_22_s");
        req(0, SH, 1, 32'h22, 0, 32'h0000_8001, 0, "ld_h_22_u");
        req(0, SW, 1, 32'h20, 0, 32'h8001_7F80, 0, "ld_w_20_u");

        req(1, SW, 0, 32'h20, 32'h1122_3344, 32'h0, 0, "st_w_20b");
        req(1, SH, 0, 32'h22, 32'h5555_ABCD, 32'h0, 0, "st_h_22");
        req(0, SW, 0, 32'h20, 0, 32'hABCD_3344, 0, "ld_w_after_h");
        req(0, SH, 0, 32'h22, 0, 32'hFFFF_ABCD, 0, "ld_h_22_abcd");
        req(1, SB, 0, 32'h21, 32'h1234_56EE, 32'h0, 0, "st_b_21");
        req(0, SW, 0, 32'h20, 0, 32'hABCD_EE44, 0, "ld_w_after_b");

        req(1, SW, 0, 32'h21, 32'hFFFF_FFFF, 32'h0, 1, "st_w_misal");
        req(0, SH, 0, 32'h23, 0, 32'h0, 1, "ld_h_misal");
        req(0, SH, 1, 32'h21, 0, 32'h0, 1, "ld_h_21_misal");
        req(1, SH, 0, 32'h23, 32'hFFFF_FFFF, 32'h0, 1, "st_h_misal");
        req(0, SW, 0, 32'h20, 0, 32'hABCD_EE44, 0, "ld_w_unchanged");
        req(0, SR, 0, 32'h20, 0, 32'h0, 1, "ld_size11");
        req(1, SR, 0, 32'h20, 32'hFFFF_FFFF, 32'h0, 1, "st_size11");
        req(0, SW, 0, 32'h20, 0, 32'hABCD_EE44, 0, "ld_w_after_s11");

        req(1, SW, 0, 32'h0, 32'h1234_5678, 32'h0, 0, "st_w_0");
        req(1, SW, 0, 32'h100, 32'hFFFF_FFFF, 32'h0, 1, "st_w_100");
        req(1, SB, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "st_b_hi");
        req(0, SW, 0, 32'h100, 0, 32'h0, 1, "ld_w_100");
        req(0, SW, 0, 32'h0, 0, 32'h1234_5678, 0, "ld_w_0_noalias");
        req(0, SW, 0, 32'hFC, 0, 32'h0, 0, "ld_w_top");

        @(posedge clock);
        #1;
        req_escrita   = 1'b0;
        req_tamanho   = SW;
        req_sem_sinal = 1'b0;
        endereco      = 32'h20;
        req_valid     = 1'b1;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            rdy[3-i] = req_ready;
            if (req_ready) begin
                acc++;
                push_exp(32'hABCD_EE44, 1'b0, "b2b_load");
            end
            @(posedge clock);
        end
        #1;
        req_valid = 1'b0;
        check("b2b_ready_pattern", {28'b0, rdy}, 32'h0000_000A);
        check("b2b_accepts", acc, 32'd2);

        repeat (3) @(posedge clock);
        #1;
        req_escrita = 1'b1;
        req_tamanho = SW;
        endereco    = 32'h30;
        valor_reg2  = 32'hDEAD_BEEF;
        req_valid   = 1'b1;
        reset       = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("rst2_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst2_ready", {31'b0, req_ready}, 32'd1);
        req(0, SW, 0, 32'h30, 0, 32'h0, 0, "ld_w_30_dropped");
        req(0, SW, 0, 32'h20, 0, 32'h0, 0, "ld_w_20_cleared");

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
